// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: sequences the 5-stage pipeline around the ID stage.
// Produces stage enables, bubbles and flushes from load-use/RAW hazards,
// taken branches resolved in EX and data-memory busy. It also drives the
// operand forwarding selects and keeps stall/flush statistics plus a sticky
// memory-timeout flag.
// Optional feature: define HAZ_FORWARDING_EN to enable EX/MEM/WB forwarding.
// Without it, every RAW match stalls until the producer retires.
module pipeline_hazard_controller #(
    parameter int REG_W       = 4,
    parameter int PC_REG      = 15,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_rf_enable,
    input  logic             ex_load_instr,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_rf_enable,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_rf_enable,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_nop,
    output logic             ex_mem_enable,
    output logic             mem_wb_nop,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int               WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic              ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
    logic              hazard;
    logic [1:0]        fwd_a_raw, fwd_b_raw;

    // Source/producer matching; unused sources and the PC index never match.
    always_comb begin
        ex_a  = id_use_rn && (id_rn != PC_IDX) && ex_rf_enable  && (ex_rd  == id_rn);
        mem_a = id_use_rn && (id_rn != PC_IDX) && mem_rf_enable && (mem_rd == id_rn);
        wb_a  = id_use_rn && (id_rn != PC_IDX) && wb_rf_enable  && (wb_rd  == id_rn);
        ex_b  = id_use_rm && (id_rm != PC_IDX) && ex_rf_enable  && (ex_rd  == id_rm);
        mem_b = id_use_rm && (id_rm != PC_IDX) && mem_rf_enable && (mem_rd == id_rm);
        wb_b  = id_use_rm && (id_rm != PC_IDX) && wb_rf_enable  && (wb_rd  == id_rm);
    end

`ifdef HAZ_FORWARDING_EN
    // Forward youngest producer first; a load in EX has no data yet, so it stalls instead.
    always_comb begin
        hazard    = ex_load_instr && (ex_a || ex_b);
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (ex_a && !ex_load_instr) fwd_a_raw = 2'b01;
        else if (mem_a)             fwd_a_raw = 2'b10;
        else if (wb_a)              fwd_a_raw = 2'b11;
        if (ex_b && !ex_load_instr) fwd_b_raw = 2'b01;
        else if (mem_b)             fwd_b_raw = 2'b10;
        else if (wb_b)              fwd_b_raw = 2'b11;
    end
`else
    // No bypass network: any in-flight producer of a source holds the ID instruction.
    always_comb begin
        hazard    = ex_a || mem_a || wb_a || ex_b || mem_b || wb_b;
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
    end
`endif

    // Mealy control: priority reset > mem_busy > taken branch > hazard > run.
    always_comb begin
        pc_enable      = 1'b1;
        if_id_enable   = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_nop      = 1'b0;
        ex_mem_enable  = 1'b1;
        mem_wb_nop     = 1'b0;
        fwd_a_sel      = fwd_a_raw;
        fwd_b_sel      = fwd_b_raw;
        state_d        = RUN;
        wait_d         = '0;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        mem_timeout_d  = mem_timeout_q;
        if (reset) begin
            pc_enable      = 1'b0;
            if_id_enable   = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_nop      = 1'b1;
            ex_mem_enable  = 1'b0;
            mem_wb_nop     = 1'b1;
            fwd_a_sel      = 2'b00;
            fwd_b_sel      = 2'b00;
            stall_cycles_d = '0;
            flush_count_d  = '0;
            mem_timeout_d  = 1'b0;
        end else begin
            if (mem_busy) begin
                // Freeze: ID/EX holds its contents, only MEM/WB takes a bubble.
                pc_enable     = 1'b0;
                if_id_enable  = 1'b0;
                ex_mem_enable = 1'b0;
                mem_wb_nop    = 1'b1;
                state_d       = MEM_WAIT;
                if (state_q != MEM_WAIT)  wait_d = WAIT_W'(1);
                else if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
                else                      wait_d = wait_q;
                if (wait_d == WAIT_MAX) mem_timeout_d = 1'b1;
            end else if (ex_branch_taken) begin
                // Wrong-path instructions in IF/ID and ID are squashed; hazards are moot.
                if_id_flush = 1'b1;
                id_ex_nop   = 1'b1;
                if (!(&flush_count_q)) flush_count_d = flush_count_q + CNT_W'(1);
            end else if (hazard) begin
                pc_enable    = 1'b0;
                if_id_enable = 1'b0;
                id_ex_nop    = 1'b1;
                state_d      = STALL;
            end
            if (!pc_enable && !(&stall_cycles_q))
                stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State, wait counter and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            wait_q         <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            mem_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
            mem_timeout_q  <= mem_timeout_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus randomized
// traffic compared every cycle against a behavioural reference model.
module tb_pipeline_hazard_controller;
    localparam int REG_W = 4, PC_REG = 15, CNT_W = 5, MEM_TO = 8;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
    logic id_use_rn, id_use_rm, ex_rf_enable, ex_load_instr, mem_rf_enable, wb_rf_enable;
    logic ex_branch_taken, mem_busy;
    logic pc_enable, if_id_enable, if_id_flush, id_ex_nop, ex_mem_enable, mem_wb_nop;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic mem_timeout;

    pipeline_hazard_controller #(.REG_W(REG_W), .PC_REG(PC_REG), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
        .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable), .ex_load_instr(ex_load_instr),
        .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable), .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush), .id_ex_nop(id_ex_nop),
        .ex_mem_enable(ex_mem_enable), .mem_wb_nop(mem_wb_nop), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_stall, m_flush, m_wait;
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit dep(input logic [3:0] src, input bit used, input logic [3:0] rd, input bit en);
        return used && (src != PC_REG) && en && (rd == src);
    endfunction

    // Forward select: first producer, youngest to oldest, whose data already exists.
    function automatic logic [1:0] fsel(input logic [3:0] src, input bit used);
        logic [3:0] rds [3];
        bit ens [3];
        rds = '{ex_rd, mem_rd, wb_rd};
        ens = '{ex_rf_enable, mem_rf_enable, wb_rf_enable};
        for (int i = 0; i < 3; i++) begin
            if (i == 0 && ex_load_instr) continue;
            if (dep(src, used, rds[i], ens[i])) return 2'(i + 1);
        end
        return 2'b00;
    endfunction

    // Expected {pc, if_id_en, flush, id_ex_nop, ex_mem_en, mem_wb_nop, fwd_a, fwd_b}.
    function automatic logic [9:0] exp_out();
        logic [1:0] fa, fb;
        bit haz;
        bit any_a, any_b;
        if (reset) return 10'b0011_01_0000;
`ifdef HAZ_FORWARDING_EN
        fa  = fsel(id_rn, id_use_rn);
        fb  = fsel(id_rm, id_use_rm);
        haz = ex_load_instr && (dep(id_rn, id_use_rn, ex_rd, ex_rf_enable) || dep(id_rm, id_use_rm, ex_rd, ex_rf_enable));
`else
        fa = 2'b00;
        fb = 2'b00;
        any_a = dep(id_rn, id_use_rn, ex_rd, ex_rf_enable) || dep(id_rn, id_use_rn, mem_rd, mem_rf_enable)
              || dep(id_rn, id_use_rn, wb_rd, wb_rf_enable);
        any_b = dep(id_rm, id_use_rm, ex_rd, ex_rf_enable) || dep(id_rm, id_use_rm, mem_rd, mem_rf_enable)
              || dep(id_rm, id_use_rm, wb_rd, wb_rf_enable);
        haz = any_a || any_b;
`endif
        if (mem_busy)        return {6'b0000_01, fa, fb};
        if (ex_branch_taken) return {6'b1111_10, fa, fb};
        if (haz)             return {6'b0001_10, fa, fb};
        return {6'b1100_10, fa, fb};
    endfunction

    task automatic model_edge(input bit pc_exp);
        if (reset) begin
            m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
        end else begin
            if (!pc_exp && m_stall < CMAX) m_stall++;
            if (!mem_busy && ex_branch_taken && m_flush < CMAX) m_flush++;
            if (mem_busy) begin
                if (m_wait < MEM_TO) m_wait++;
                if (m_wait >= MEM_TO) m_to = 1;
            end else m_wait = 0;
        end
    endtask

    // One clock: check Mealy outputs before the edge, statistics after it.
    task automatic cycle();
        logic [9:0] e;
        e = exp_out();
        #1;
        chk("outs", {22'd0, pc_enable, if_id_enable, if_id_flush, id_ex_nop, ex_mem_enable, mem_wb_nop,
                     fwd_a_sel, fwd_b_sel}, {22'd0, e});
        @(posedge clk);
        model_edge(e[9]);
        #1;
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        chk("flush_count", 32'(flush_count), 32'(m_flush));
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
    endtask

    task automatic idle();
        reset = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
        ex_rd = 0; ex_rf_enable = 0; ex_load_instr = 0; mem_rd = 0; mem_rf_enable = 0;
        wb_rd = 0; wb_rf_enable = 0; ex_branch_taken = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cycle();
        chk("rst_outs", {26'd0, pc_enable, if_id_enable, if_id_flush, id_ex_nop, ex_mem_enable, mem_wb_nop},
            32'b001101);
        chk("rst_fwd", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
        idle();
    endtask

    function automatic logic [3:0] rreg();
        case ($urandom_range(0, 4))
            0: return 4'd3;
            1: return 4'd5;
            2: return 4'd7;
            3: return 4'd15;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        idle();
        @(posedge clk); #1;
        do_reset();
        chk("rst_stall", 32'(stall_cycles), 32'd0);

`ifdef HAZ_FORWARDING_EN
        // Load-use: one bubble, then the load value comes from MEM.
        ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 3; id_rn = 3; id_use_rn = 1;
        cycle();
        chk("lu_pc", 32'(pc_enable), 32'd0);
        chk("lu_nop", 32'(id_ex_nop), 32'd1);
        ex_load_instr = 0; ex_rf_enable = 0; mem_rd = 3; mem_rf_enable = 1;
        cycle();
        chk("lu_fwd_a", 32'(fwd_a_sel), 32'd2);
        chk("lu_pc2", 32'(pc_enable), 32'd1);
        chk("lu_stalls", 32'(stall_cycles), 32'd1);
        do_reset();
        // EX beats MEM; the PC index is never forwarded.
        ex_rd = 5; ex_rf_enable = 1; mem_rd = 5; mem_rf_enable = 1; id_rm = 5; id_use_rm = 1;
        id_rn = 15; id_use_rn = 1; wb_rd = 15; wb_rf_enable = 1;
        cycle();
        chk("pri_fwd_b", 32'(fwd_b_sel), 32'd1);
        chk("pc_fwd_a", 32'(fwd_a_sel), 32'd0);
        do_reset();
`else
        // RAW against MEM then WB: two stall cycles, no forwarding.
        mem_rd = 7; mem_rf_enable = 1; id_rn = 7; id_use_rn = 1;
        cycle();
        chk("raw_pc1", 32'(pc_enable), 32'd0);
        mem_rf_enable = 0; wb_rd = 7; wb_rf_enable = 1;
        cycle();
        chk("raw_pc2", 32'(pc_enable), 32'd0);
        chk("raw_fwd", {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
        wb_rf_enable = 0;
        cycle();
        chk("raw_release", 32'(pc_enable), 32'd1);
        chk("raw_stalls", 32'(stall_cycles), 32'd2);
        do_reset();
`endif
        // Taken branch wins over a coincident load-use hazard.
        ex_branch_taken = 1; ex_load_instr = 1; ex_rf_enable = 1; ex_rd = 3; id_rn = 3; id_use_rn = 1;
        cycle();
        chk("br_flush", {29'd0, if_id_flush, id_ex_nop, pc_enable}, 32'b111);
        chk("br_count", 32'(flush_count), 32'd1);
        chk("br_nostall", 32'(stall_cycles), 32'd0);
        do_reset();

        // Three busy cycles: frozen, then running again on the fourth.
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("busy_en", {29'd0, pc_enable, if_id_enable, ex_mem_enable}, 32'd0);
        end
        mem_busy = 0;
        cycle();
        chk("busy_run", 32'(pc_enable), 32'd1);
        chk("busy_stalls", 32'(stall_cycles), 32'd3);
        chk("busy_noto", 32'(mem_timeout), 32'd0);
        do_reset();

        // Eight busy cycles set the sticky timeout.
        mem_busy = 1;
        for (int i = 0; i < 7; i++) cycle();
        chk("to_early", 32'(mem_timeout), 32'd0);
        cycle();
        chk("to_set", 32'(mem_timeout), 32'd1);
        mem_busy = 0;
        cycle();
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        do_reset();
        chk("to_cleared", 32'(mem_timeout), 32'd0);

        // Randomized traffic; long runs also exercise counter saturation.
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 99) < 2);
            id_rn           = rreg();
            id_rm           = rreg();
            id_use_rn       = $urandom_range(0, 3) != 0;
            id_use_rm       = $urandom_range(0, 1) != 0;
            ex_rd           = rreg();
            mem_rd          = rreg();
            wb_rd           = rreg();
            ex_rf_enable    = $urandom_range(0, 1) != 0;
            ex_load_instr   = $urandom_range(0, 2) == 0;
            mem_rf_enable   = $urandom_range(0, 1) != 0;
            wb_rf_enable    = $urandom_range(0, 1) != 0;
            ex_branch_taken = $urandom_range(0, 6) == 0;
            mem_busy        = (n % 200 > 185) || ($urandom_range(0, 6) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
